// File: rtl/ccc_rst_pkg.sv
// ---------------------------------------------------------------------------
// ccc_rst_pkg
// Shared definitions for the CCC lock-qualified reset generator:
//   - rst_state_t : 2-bit FSM state type (WAIT_LOCK=0, FILTER=1, HOLD=2, RUN=3)
//   - DEF_*       : default parameter values for ccc_lock_reset_gen
//   - clog2 / cnt_width : width helpers for the shared phase counter
// ---------------------------------------------------------------------------
package ccc_rst_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_FILTER    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } rst_state_t;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_LOCK_FILTER_CYCLES = 1024;
  localparam int DEF_RESET_HOLD_CYCLES  = 16;
  localparam int DEF_LOSS_CNT_W         = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // One counter serves both the filter and hold phases, so it is sized for
  // the longer of the two; never narrower than one bit so that windows of
  // length 1 still produce a legal vector.
  function automatic int cnt_width(input int filt_cycles, input int hold_cycles);
    int m;
    int w;
    m = (filt_cycles > hold_cycles) ? filt_cycles : hold_cycles;
    w = clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ccc_lock_reset_gen_sync_bit.sv
// ---------------------------------------------------------------------------
// sync_bit
// N-stage single-bit synchroniser with asynchronous active-high clear.
//   clk : destination clock
//   clr : asynchronous clear, active-high; forces every stage to 0
//   d   : asynchronous input bit
//   q   : synchronised output (last stage)
// STAGES must be at least 2.
// ---------------------------------------------------------------------------
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ccc_lock_reset_gen.sv
// ---------------------------------------------------------------------------
// ccc_lock_reset_gen
// Qualified system reset generator sitting behind the fabric CCC/PLL.
// SYS_RESET asserts at once on RESET or (after synchronisation) on loss of
// LOCK, and is released synchronously only once LOCK has been stable for
// LOCK_FILTER_CYCLES followed by RESET_HOLD_CYCLES.
//
// Ports:
//   CLK           : CCC GL0, the only clock
//   RESET         : external reset, asynchronous, active-high
//   LOCK          : CCC lock flag, asynchronous to CLK
//   SYS_RESET     : qualified reset, active-high (async assert, sync release)
//   READY         : high while in RUN (complement of SYS_RESET outside RESET)
//   READY_PULSE   : single-cycle pulse on entry to RUN
//   LOCK_LOSS_CNT : saturating count of RUN -> WAIT_LOCK exits
//   STATE         : current FSM state, for debug
//
// Parameter legal ranges: SYNC_STAGES 2..4, LOCK_FILTER_CYCLES >= 1,
// RESET_HOLD_CYCLES >= 1, LOSS_CNT_W >= 1.
// ---------------------------------------------------------------------------
module ccc_lock_reset_gen
  import ccc_rst_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_FILTER_CYCLES = DEF_LOCK_FILTER_CYCLES,
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
  parameter int LOSS_CNT_W         = DEF_LOSS_CNT_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  LOCK,
  output logic                  SYS_RESET,
  output logic                  READY,
  output logic                  READY_PULSE,
  output logic [LOSS_CNT_W-1:0] LOCK_LOSS_CNT,
  output logic [1:0]            STATE
);

  localparam int CNT_W = cnt_width(LOCK_FILTER_CYCLES, RESET_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);

  rst_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;

  // Loss counter sticks at all-ones rather than wrapping, so a flapping PLL
  // cannot masquerade as a quiet one.
  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // --- LOCK synchronisation: lock_s is the only form of LOCK used below ---
  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (CLK),
    .clr (RESET),
    .d   (LOCK),
    .q   (lock_s)
  );

  // --- Qualification FSM with registered outputs ---
  // Any drop of lock_s before RUN sends the FSM back to WAIT_LOCK, which
  // restarts the filter window from zero on the next high sample.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= ST_WAIT_LOCK;
      cnt           <= '0;
      SYS_RESET     <= 1'b1;
      READY         <= 1'b0;
      READY_PULSE   <= 1'b0;
      LOCK_LOSS_CNT <= '0;
    end else begin
      READY_PULSE <= 1'b0;
      case (state)
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state <= ST_FILTER;
            cnt   <= '0;
          end
        end
        ST_FILTER: begin
          if (!lock_s) begin
            state <= ST_WAIT_LOCK;
          end else if (cnt == FILT_LAST) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          // Losing lock here is a failed bring-up, not a loss from RUN,
          // so the loss counter is left alone.
          if (!lock_s) begin
            state <= ST_WAIT_LOCK;
          end else if (cnt == HOLD_LAST) begin
            state       <= ST_RUN;
            SYS_RESET   <= 1'b0;
            READY       <= 1'b1;
            READY_PULSE <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state         <= ST_WAIT_LOCK;
            SYS_RESET     <= 1'b1;
            READY         <= 1'b0;
            LOCK_LOSS_CNT <= sat_inc(LOCK_LOSS_CNT);
          end
        end
        default: begin
          state     <= ST_WAIT_LOCK;
          SYS_RESET <= 1'b1;
          READY     <= 1'b0;
        end
      endcase
    end
  end

  assign STATE = state;

endmodule
